datapath_sequencer: RTL

//   Shared controller for the adder/register-file datapath of the user project.
//   It arbitrates round-robin between two command requesters: [0] the logic-analyzer

---
 rtl/datapath_seq_pkg.sv | 35 +++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/datapath_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared types for the datapath sequencer: opcodes, FSM states and the packed
// command layout at the default widths.
package datapath_seq_pkg;

    localparam int unsigned PKG_DW = 16;
    localparam int unsigned PKG_AW = 3;
    localparam int unsigned PKG_CW = 2 + 3 * PKG_AW + PKG_DW;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_LDI  = 2'b01,
        OP_RD   = 2'b10,
        OP_ADDI = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    typedef struct packed {
        op_e                op;
        logic [PKG_AW-1:0]  rd;
        logic [PKG_AW-1:0]  rs1;
        logic [PKG_AW-1:0]  rs2;
        logic [PKG_DW-1:0]  imm;
    } cmd_t;

    function automatic logic op_writes(input op_e op);
        return op != OP_RD;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer only advances on an
// accepted transfer, so a requester that drops valid early loses nothing.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] ready_o,
    output logic       grant_o,
    output logic       accept_o
);

    logic last_q;

    always_comb begin
        grant_o = 1'b0;
        if (valid_i == 2'b11) begin
            grant_o = ~last_q;
        end else if (valid_i[1]) begin
            grant_o = 1'b1;
        end
        ready_o = '0;
        if (en_i && (valid_i != 2'b00)) begin
            ready_o = grant_o ? 2'b10 : 2'b01;
        end
    end

    assign accept_o = |(valid_i & ready_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (accept_o) begin
            last_q <= grant_o;
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Serial controller for the adder/regfile datapath: arbitrates two requesters,
// then walks each command through READ, EXEC and WB and returns one response.
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 3,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                         clock,
    input  logic                         resetb,
    input  logic [1:0]                   req_valid,
    output logic [1:0]                   req_ready,
    input  logic [2*(2+3*AW+DW)-1:0]     req_cmd,
    output logic [1:0]                   resp_valid,
    output logic [DW-1:0]                resp_data,
    output logic                         resp_carry,
    output logic [AW-1:0]                rf_ra1,
    output logic [AW-1:0]                rf_ra2,
    input  logic [DW-1:0]                rf_rd1,
    input  logic [DW-1:0]                rf_rd2,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_wa,
    output logic [DW-1:0]                rf_wd,
    output logic [DW-1:0]                add_a,
    output logic [DW-1:0]                add_b,
    input  logic [DW-1:0]                add_sum,
    input  logic                         add_cout,
    output logic                         busy,
    output logic [15:0]                  op_count
);

    localparam int unsigned CW = 2 + 3 * AW + DW;

    state_e         state_q;
    op_e            op_q;
    logic           grant_q;
    logic [AW-1:0]  rd_q;
    logic [DW-1:0]  imm_q;
    logic [AW-1:0]  rf_ra1_q, rf_ra2_q, rf_wa_q;
    logic           rf_we_q;
    logic [DW-1:0]  rf_wd_q;
    logic [1:0]     resp_valid_q;
    logic [DW-1:0]  resp_data_q;
    logic           resp_carry_q;
    logic [15:0]    op_count_q;

    logic           arb_en, arb_grant, accept;
    logic [CW-1:0]  win_cmd;
    logic [DW-1:0]  exec_result;
    logic           exec_carry;

    // Ready is gated by reset so every output reads 0 while resetb is low.
    assign arb_en = (state_q == ST_IDLE) && resetb;

    rr_arbiter2 u_arb (
        .clk_i    (clock),
        .rst_ni   (resetb),
        .valid_i  (req_valid),
        .en_i     (arb_en),
        .ready_o  (req_ready),
        .grant_o  (arb_grant),
        .accept_o (accept)
    );

    assign win_cmd = arb_grant ? req_cmd[2*CW-1:CW] : req_cmd[CW-1:0];

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state_q == ST_EXEC) begin
            add_a = rf_rd1;
            add_b = (op_q == OP_ADDI) ? imm_q : rf_rd2;
        end
    end

    always_comb begin
        exec_result = add_sum;
        exec_carry  = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDI: begin
                exec_result = add_sum;
                exec_carry  = add_cout;
            end
            OP_LDI:  exec_result = imm_q;
            OP_RD:   exec_result = rf_rd1;
            default: exec_result = add_sum;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ADD;
            grant_q      <= 1'b0;
            rd_q         <= '0;
            imm_q        <= '0;
            rf_ra1_q     <= '0;
            rf_ra2_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            rf_ra1_q     <= '0;
            rf_ra2_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
            resp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op_e'(win_cmd[CW-1 -: 2]);
                        rd_q     <= win_cmd[DW+3*AW-1 -: AW];
                        imm_q    <= win_cmd[DW-1:0];
                        grant_q  <= arb_grant;
                        rf_ra1_q <= win_cmd[DW+2*AW-1 -: AW];
                        rf_ra2_q <= win_cmd[DW+AW-1 -: AW];
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: state_q <= ST_EXEC;
                ST_EXEC: begin
                    // WB-cycle outputs are registered here so they are clean for the whole WB cycle.
                    resp_data_q  <= exec_result;
                    resp_carry_q <= exec_carry;
                    resp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    rf_we_q      <= op_writes(op_q) && !(ZERO_REG && (rd_q == '0));
                    rf_wa_q      <= rd_q;
                    rf_wd_q      <= exec_result;
                    state_q      <= ST_WB;
                end
                ST_WB: begin
                    op_count_q <= op_count_q + 16'd1;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rf_ra1     = rf_ra1_q;
    assign rf_ra2     = rf_ra2_q;
    assign rf_we      = rf_we_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_carry = resp_carry_q;
    assign busy       = (state_q != ST_IDLE);
    assign op_count   = op_count_q;

endmodule
